// File: rtl/bp_io_reg_responder.sv
// IO register responder: terminates a command/response wormhole link pair.
// Each command packet is decoded, run against a small register bank, and
// answered with exactly one response packet. Only one packet is in flight,
// so commands and responses stay in order.
//
// Handshake: a flit moves on a link in a cycle where valid and ready_and are
// both high at the rising edge. Valid never depends on ready. Once valid is
// raised, the flit stays unchanged until it is accepted. cmd_ready_and_o is
// a function of the registered state only.
module bp_io_reg_responder #(
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4,
    parameter int addr_width_p = 16,
    parameter int num_regs_p   = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [cord_width_p-1:0] my_cord_i,
    input  logic                    cmd_v_i,
    input  logic [flit_width_p-1:0] cmd_data_i,
    output logic                    cmd_ready_and_o,
    output logic                    resp_v_o,
    output logic [flit_width_p-1:0] resp_data_o,
    input  logic                    resp_ready_and_i
);

    localparam int idx_w_lp    = $clog2(num_regs_p);
    localparam int len_lsb_lp  = cord_width_p;
    localparam int src_lsb_lp  = len_lsb_lp + len_width_p;
    localparam int op_lsb_lp   = src_lsb_lp + cord_width_p;
    localparam int addr_lsb_lp = op_lsb_lp + 2;
    localparam int err_lsb_lp  = addr_lsb_lp + addr_width_p;

    localparam logic [1:0] op_read_lp  = 2'd0;
    localparam logic [1:0] op_write_lp = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_DATA, S_DRAIN, S_RESP_HDR, S_RESP_DATA
    } state_e;

    state_e                  state_q, state_d;
    logic [cord_width_p-1:0] src_q, src_d;
    logic [1:0]              op_q, op_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic [len_width_p-1:0]  len_q, len_d;
    logic [len_width_p-1:0]  cnt_q, cnt_d;
    logic [flit_width_p-1:0] rd_data_q, rd_data_d;
    logic [flit_width_p-1:0] regs_q [num_regs_p];
    logic [flit_width_p-1:0] regs_d [num_regs_p];

    // Header fields of the incoming flit (only meaningful in IDLE).
    logic [len_width_p-1:0]  hdr_len;
    logic [1:0]              hdr_op;
    logic [idx_w_lp-1:0]     hdr_idx;

    // Decode of the latched command.
    logic                    in_range;
    logic                    legal;
    logic                    legal_read;
    logic [idx_w_lp-1:0]     idx;

    // Field extraction and legality of the latched command.
    always_comb begin
        hdr_len    = cmd_data_i[len_lsb_lp +: len_width_p];
        hdr_op     = cmd_data_i[op_lsb_lp +: 2];
        hdr_idx    = cmd_data_i[addr_lsb_lp + 3 +: idx_w_lp];
        idx        = addr_q[3 +: idx_w_lp];
        in_range   = (addr_q[addr_width_p-1:3] < (addr_width_p-3)'(num_regs_p));
        legal_read = in_range && (op_q == op_read_lp) && (len_q == '0);
        legal      = legal_read
                     || (in_range && (op_q == op_write_lp) && (len_q == len_width_p'(1)));
    end

    // Next-state, datapath updates and link outputs.
    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        op_d            = op_q;
        addr_d          = addr_q;
        len_d           = len_q;
        cnt_d           = cnt_q;
        rd_data_d       = rd_data_q;
        regs_d          = regs_q;
        cmd_ready_and_o = 1'b0;
        resp_v_o        = 1'b0;
        resp_data_o     = '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_and_o = 1'b1;
                if (cmd_v_i) begin
                    src_d  = cmd_data_i[src_lsb_lp +: cord_width_p];
                    op_d   = hdr_op;
                    addr_d = cmd_data_i[addr_lsb_lp +: addr_width_p];
                    len_d  = hdr_len;
                    // Read data is sampled here; it is only returned for legal reads.
                    rd_data_d = regs_q[hdr_idx];
                    if (hdr_len == '0) begin
                        state_d = S_RESP_HDR;
                    end else if ((hdr_op == op_write_lp) && (hdr_len == len_width_p'(1))) begin
                        state_d = S_DATA;
                    end else begin
                        cnt_d   = hdr_len;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DATA: begin
                cmd_ready_and_o = 1'b1;
                if (cmd_v_i) begin
                    if (legal) begin
                        regs_d[idx] = cmd_data_i;
                    end
                    state_d = S_RESP_HDR;
                end
            end
            S_DRAIN: begin
                cmd_ready_and_o = 1'b1;
                if (cmd_v_i) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = S_RESP_HDR;
                    end
                end
            end
            S_RESP_HDR: begin
                resp_v_o = 1'b1;
                resp_data_o[0 +: cord_width_p]            = src_q;
                resp_data_o[len_lsb_lp +: len_width_p]    = legal_read ? len_width_p'(1) : '0;
                resp_data_o[src_lsb_lp +: cord_width_p]   = my_cord_i;
                resp_data_o[op_lsb_lp +: 2]               = op_q;
                resp_data_o[addr_lsb_lp +: addr_width_p]  = addr_q;
                resp_data_o[err_lsb_lp]                   = !legal;
                if (resp_ready_and_i) begin
                    state_d = legal_read ? S_RESP_DATA : S_IDLE;
                end
            end
            S_RESP_DATA: begin
                resp_v_o    = 1'b1;
                resp_data_o = rd_data_q;
                if (resp_ready_and_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any packet and clears the bank.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            for (int i = 0; i < num_regs_p; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i < num_regs_p; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: doc/bp_io_reg_responder.md
Name: bp_io_reg_responder

Overview:
- Endpoint at the far end of an IO command/response wormhole link pair.
- Accepts command packets, executes reads/writes against a local register bank, returns one response packet per command.
- Sits on a mesh port and acts as the target that IO tiles' command traffic reaches.
- Processes one packet at a time, so the command and response streams are strictly ordered.

Parameters:
- flit_width_p, 64: width of command and response flits.
- cord_width_p, 8: width of the mesh coordinate fields.
- len_width_p, 4: width of the packet length field (number of flits after the header).
- addr_width_p, 16: width of the byte address field.
- num_regs_p, 8: number of 64-bit registers; must be a power of 2, ≥2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- my_cord_i  in  cord_width_p  this endpoint's coordinate; written into the response source field
- cmd_v_i  in  1  command flit valid
- cmd_data_i  in  flit_width_p  command flit
- cmd_ready_and_o  out  1  command flit accepted when v & ready_and
- resp_v_o  out  1  response flit valid
- resp_data_o  out  flit_width_p  response flit
- resp_ready_and_i  in  1  downstream ready; flit transfers when v & ready_and

Behaviour:
- Header flit layout, unused bits zero:
  - dst [7:0]
  - len [11:8]
  - src [19:12]
  - op [21:20]
  - addr [37:22]
  - err [38] (responses only)
  - Positions shown for the default parameters; fields pack LSB-first in this order for any width.
- Op encoding: 0 = read, 1 = write, 2–3 = unsupported.
- Register index = addr[3 +: log2(num_regs_p)]. Address is in range iff addr[addr_width_p-1:3] < num_regs_p.
- A command is legal iff:
  - op = read, len = 0 and address in range; or
  - op = write, len = 1 and address in range.
- FSM states: IDLE, DATA, DRAIN, RESP_HDR, RESP_DATA.
- IDLE:
  - cmd_ready_and_o = 1.
  - On header accept, latch src, op, addr and len.
  - len = 0 → RESP_HDR.
  - Write with len = 1 → DATA.
  - Any other len > 0 → DRAIN, with the drain counter = len.
- DATA:
  - cmd_ready_and_o = 1.
  - On accept, if legal, write the flit into the register at the rising edge of acceptance. Then → RESP_HDR.
- DRAIN:
  - cmd_ready_and_o = 1.
  - Each accepted flit decrements the counter; the flits are discarded.
  - When the counter reaches 1 and a flit is accepted → RESP_HDR with err = 1.
  - No register is modified.
- RESP_HDR:
  - cmd_ready_and_o = 0, resp_v_o = 1.
  - Header fields:
    - dst = latched src
    - src = my_cord_i
    - op and addr echoed
    - err = !legal
    - len = 1 if legal read, else 0
  - On handshake: len = 1 → RESP_DATA, else → IDLE.
- RESP_DATA:
  - resp_v_o = 1, data = register value captured at header accept.
  - On handshake → IDLE.
- Back-pressure: resp_data_o and resp_v_o stay stable while resp_ready_and_i = 0. No combinational path from resp_ready_and_i to resp_v_o.
- cmd_ready_and_o depends only on state (registered), never on cmd_v_i.
- Latency: header accept → resp_v_o asserted takes 1 cycle for a read, and 1 cycle after data-flit accept for a write.
- Minimum throughput:
  - Read: 3 cycles/packet with the downstream always ready.
  - Write: 3 cycles/packet (header, data, response header).
- Reset:
  - State → IDLE.
  - resp_v_o = 0 and resp_data_o = 0.
  - cmd_ready_and_o = 1 on the first cycle after reset.
  - All registers cleared to 0.
  - Any in-flight packet is abandoned and no response is emitted for it.
- A zero-length header with unsupported op gets an err response with len 0.

Test Plan:
- Reset, then read addr 0x10 (len 0, src 0x21) with my_cord_i = 0x05 → header dst = 0x21, src = 0x05, op 0, len 1, err 0; then data flit 0.
- Write addr 0x08 data 0xDEAD_BEEF_0123_4567, then read addr 0x08 → write response len 0, err 0; read data 0xDEAD_BEEF_0123_4567.
- Read addr 0x40 (index 8, out of range) → single response header, err = 1, len 0; the register bank is unchanged.
- Write with len 3 → three payload flits accepted and dropped, then one err = 1 response; a follow-up read of the target register returns its prior value.
- Hold resp_ready_and_i = 0 for 5 cycles during RESP_HDR → resp_v_o stays 1 with stable data, cmd_ready_and_o = 0, no extra command flits are accepted.
- Assert reset_i while in DATA → no response is emitted, the register is not written, cmd_ready_and_o = 1 the next cycle.
